// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops a fixed-length burst from a synchronous FIFO with
// one-cycle registered read latency and re-presents the words as a
// valid/ready stream with a last-word flag. A 3-entry output buffer plus a
// one-bit in-flight credit absorbs the FIFO latency so the stream can run at
// one word per cycle and stay safe under backpressure.
module fifo_stream_reader #(
    parameter int data_width = 25,
    parameter int len_width  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  start,
    input  logic [len_width-1:0]  len,
    output logic                  busy,
    output logic                  done,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [data_width-1:0] fifo_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [data_width-1:0] m_data,
    output logic                  m_last
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q;
    logic [len_width-1:0]  remaining_issue_q;
    logic [len_width-1:0]  remaining_out_q;
    logic [1:0]            occ_q;
    logic [1:0]            head_q;
    logic [1:0]            tail_q;
    logic                  inflight_q;
    logic [data_width-1:0] obuf_q [3];

    logic                  capture;
    logic                  xfer;
    logic [2:0]            credit_used;

    // Pointer advance with wrap over the three buffer slots.
    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credit counts buffered words plus the word still inside the FIFO's
    // read register, so the buffer can never be overrun and the pop request
    // never depends on m_ready.
    always_comb begin
        credit_used = {1'b0, occ_q} + {2'b00, inflight_q};
        fifo_rd_en  = (state_q == S_RUN) && !stall && !fifo_empty &&
                      (remaining_issue_q != '0) && (credit_used < 3'd3);
        capture     = inflight_q && !stall;
        m_valid     = (occ_q != 2'd0) && !stall;
        xfer        = m_valid && m_ready;
        m_data      = obuf_q[head_q];
        m_last      = m_valid && (remaining_out_q == len_width'(1));
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
    end

    // Output buffer slots: each one loads the FIFO read data when it is the
    // tail and the word popped last cycle lands.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_obuf
            always_ff @(posedge clk) begin
                if (rst) begin
                    obuf_q[gi] <= '0;
                end else if (capture && (tail_q == 2'(gi))) begin
                    obuf_q[gi] <= fifo_dout;
                end
            end
        end
    endgenerate

    // Control FSM with burst counters, occupancy and in-flight tracking;
    // stall freezes every register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= S_IDLE;
            remaining_issue_q <= '0;
            remaining_out_q   <= '0;
            occ_q             <= 2'd0;
            head_q            <= 2'd0;
            tail_q            <= 2'd0;
            inflight_q        <= 1'b0;
        end else if (!stall) begin
            inflight_q <= fifo_rd_en;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        remaining_issue_q <= len;
                        remaining_out_q   <= len;
                        state_q           <= (len == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (fifo_rd_en) begin
                        remaining_issue_q <= remaining_issue_q - len_width'(1);
                    end
                    if (capture) begin
                        tail_q <= next_ptr(tail_q);
                    end
                    if (xfer) begin
                        head_q          <= next_ptr(head_q);
                        remaining_out_q <= remaining_out_q - len_width'(1);
                    end
                    if (capture && !xfer) begin
                        occ_q <= occ_q + 2'd1;
                    end else if (!capture && xfer) begin
                        occ_q <= occ_q - 2'd1;
                    end
                    if (xfer && (remaining_out_q == len_width'(1))) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed testbench for fifo_stream_reader with a behavioural synchronous
// FIFO (one-cycle registered read, shares the stall) and a stream monitor.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        start = 1'b0;
    logic [15:0] len = '0;
    logic        busy;
    logic        done;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [24:0] fifo_dout = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [24:0] m_data;
    logic        m_last;

    int checks = 0;
    int failures = 0;

    // FIFO model state
    logic [24:0] fq [$];
    int pushes = 0;
    int pops = 0;

    // Received stream words: {last, data}
    logic [25:0] rx [$];

    fifo_stream_reader #(.data_width(25), .len_width(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (pushes == pops);

    // Behavioural FIFO read port
    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty && !stall) begin
            fifo_dout <= fq.pop_front();
            pops      <= pops + 1;
        end
    end

    // Stream monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            rx.push_back({m_last, m_data});
            $display("xfer data=%h last=%0b", m_data, m_last);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [24:0] w);
        fq.push_back(w);
        pushes = pushes + 1;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 200) begin
            cyc();
            #1;
            n++;
        end
        chk(tag, (n < 200), 1);
    endtask

    task automatic check_rx(input string tag, input int base, input int n);
        chk({tag, "_count"}, rx.size(), n);
        for (int i = 0; i < n && i < rx.size(); i++) begin
            chk({tag, "_word"}, rx[i], {(i == n - 1), 25'(base + i)});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;

        // ---------------- reset values ----------------
        cyc();
        cyc();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        rst = 1'b0;

        // ---------------- basic burst ----------------
        cyc();
        for (int i = 0; i < 5; i++) push(25'(16'h10 + i));
        p0 = pops;
        m_ready = 1'b1;
        start = 1'b1;
        len = 16'd5;                       // cycle T
        #1;
        chk("basic_busy_T", busy, 0);
        cyc();                             // T+1
        start = 1'b0;
        #1;
        chk("basic_busy_T1", busy, 1);
        chk("basic_rd_en_T1", fifo_rd_en, 1);
        cyc();                             // T+2
        #1;
        chk("basic_valid_T2", m_valid, 0);
        for (int i = 0; i < 5; i++) begin  // T+3 .. T+7
            cyc();
            #1;
            chk("basic_valid", m_valid, 1);
            chk("basic_data", m_data, 25'(16'h10 + i));
            chk("basic_last", m_last, (i == 4));
        end
        cyc();                             // T+8
        #1;
        chk("basic_done", done, 1);
        chk("basic_valid_after", m_valid, 0);
        cyc();                             // T+9
        #1;
        chk("basic_done_clear", done, 0);
        chk("basic_busy_clear", busy, 0);
        chk("basic_pops", pops - p0, 5);

        // ---------------- backpressure (start in L+2) ----------------
        rx.delete();
        for (int i = 0; i < 8; i++) push(25'(16'h20 + i));
        p0 = pops;
        m_ready = 1'b0;
        start = 1'b1;
        len = 16'd8;                       // T
        cyc();                             // T+1
        start = 1'b0;
        cyc();                             // T+2
        cyc();                             // T+3
        #1;
        chk("bp_valid_first", m_valid, 1);
        chk("bp_data_first", m_data, 25'h20);
        for (int k = 4; k <= 8; k++) begin
            cyc();
            #1;
            chk("bp_valid_held", m_valid, 1);
            chk("bp_data_held", m_data, 25'h20);
            chk("bp_rd_en_off", fifo_rd_en, 0);
        end
        chk("bp_pops_outstanding", pops - p0, 3);
        cyc();                             // T+9
        m_ready = 1'b1;
        wait_done("bp_timeout");
        check_rx("bp", 'h20, 8);
        chk("bp_pops", pops - p0, 8);
        cyc();

        // ---------------- empty gaps ----------------
        rx.delete();
        p0 = pops;
        start = 1'b1;
        len = 16'd4;                       // T, FIFO empty
        for (int c = 1; c <= 12; c++) begin
            cyc();
            start = 1'b0;
            if (c % 3 == 1) push(25'(16'h30 + c / 3));
            #1;
            chk("gap_rd_en", fifo_rd_en, (c % 3 == 1));
        end
        wait_done("gap_timeout");
        check_rx("gap", 'h30, 4);
        chk("gap_pops", pops - p0, 4);
        cyc();

        // ---------------- stall ----------------
        rx.delete();
        for (int i = 0; i < 6; i++) push(25'(16'h40 + i));
        p0 = pops;
        start = 1'b1;
        len = 16'd6;                       // T
        cyc();                             // T+1
        start = 1'b0;
        cyc();                             // T+2
        cyc();                             // T+3
        #1;
        chk("stall_pre_data", m_data, 25'h40);
        cyc();                             // T+4, right after a pop
        stall = 1'b1;
        p0 = pops;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) cyc();
            #1;
            chk("stall_valid", m_valid, 0);
            chk("stall_rd_en", fifo_rd_en, 0);
            chk("stall_busy", busy, 1);
        end
        cyc();                             // T+8
        stall = 1'b0;
        #1;
        chk("stall_no_pops", pops - p0, 0);
        chk("stall_resume_valid", m_valid, 1);
        chk("stall_resume_data", m_data, 25'h41);
        wait_done("stall_timeout");
        check_rx("stall", 'h40, 6);
        cyc();

        // ---------------- len = 0 and start-while-busy ----------------
        rx.delete();
        for (int i = 0; i < 12; i++) push(25'(16'h50 + i));
        p0 = pops;
        start = 1'b1;
        len = 16'd0;                       // T
        cyc();                             // T+1
        start = 1'b0;
        #1;
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 1);
        chk("len0_rd_en", fifo_rd_en, 0);
        cyc();                             // T+2
        #1;
        chk("len0_done_clear", done, 0);
        chk("len0_busy_clear", busy, 0);
        chk("len0_no_pops", pops - p0, 0);
        start = 1'b1;
        len = 16'd3;
        cyc();
        start = 1'b0;
        cyc();
        start = 1'b1;
        len = 16'd9;
        cyc();
        start = 1'b0;
        wait_done("swb_timeout");
        cyc();
        cyc();
        #1;
        chk("swb_busy_after", busy, 0);
        check_rx("swb", 'h50, 3);
        chk("swb_pops", pops - p0, 3);

        // ---------------- reset mid-burst ----------------
        rx.delete();
        p0 = pops;
        start = 1'b1;
        len = 16'd6;                       // T
        cyc();                             // T+1
        start = 1'b0;
        cyc();                             // T+2
        cyc();                             // T+3
        cyc();                             // T+4
        cyc();                             // T+5
        m_ready = 1'b0;
        rst = 1'b1;
        cyc();                             // T+6
        rst = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_rd_en", fifo_rd_en, 0);
        chk("mrst_valid", m_valid, 0);
        chk("mrst_last", m_last, 0);
        chk("mrst_data", m_data, 0);
        chk("mrst_delivered", rx.size(), 2);
        chk("mrst_pops", pops - p0, 5);
        rx.delete();
        m_ready = 1'b1;
        cyc();
        start = 1'b1;
        len = 16'd2;
        cyc();
        start = 1'b0;
        wait_done("mrst_timeout");
        check_rx("mrst_new", 'h58, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
